ring_counter_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one external 8-bit ring counter (count 0..N, done pulse when count equals N while enabled, synchronous active-high clear) among NUM_REQ requesters.
- Each requester asks for a run of length len. The arbiter grants one requester, clears the counter, enables it with that requester's length, and waits for the counter's done.
- It then returns a one-cycle ack to the owner and moves priority to the next requester.
- Sits between the control FSMs of the datapath and the shared counter instance.

---
 rtl/ring_counter_arbiter.sv | 152 +++++++++++++++
 tb/tb_ring_counter_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_arbiter.sv
// Round-robin sequencer sharing one external ring counter among NUM_REQ requesters.
// Every output is a register, so requests, lengths and done only take effect at the next clock edge.
module ring_counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*CNT_W-1:0]   len_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic                       busy_o,
    output logic                       cnt_clr_o,
    output logic                       cnt_en_o,
    output logic [CNT_W-1:0]           cnt_num_o,
    input  logic                       cnt_done_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   last_r;
    logic [CNT_W-1:0]   len_q_r;

    logic [IDX_W-1:0]   pick_s;
    logic [CNT_W-1:0]   pick_len_s;
    logic               owner_req_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Scan last+NUM_REQ down to last+1 so the nearest set bit after last is kept.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        int               pos;
        pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            pos = (int'(last) + i) % NUM_REQ;
            idx = IDX_W'(pos);
            if (|(req & onehot(idx))) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Arbitration winner, its length slice and the owner's live request.
    always_comb begin
        pick_s      = rr_pick(req_i, last_r);
        pick_len_s  = '0;
        owner_req_s = |(req_i & onehot(owner_r));
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == pick_s) begin
                pick_len_s = len_i[k*CNT_W +: CNT_W];
            end else begin
                pick_len_s = pick_len_s;
            end
        end
    end

    // Sequencer FSM; outputs are loaded with the values of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            owner_r   <= '0;
            len_q_r   <= '0;
            last_r    <= IDX_W'(NUM_REQ - 1);
            gnt_o     <= '0;
            ack_o     <= '0;
            busy_o    <= 1'b0;
            cnt_clr_o <= 1'b0;
            cnt_en_o  <= 1'b0;
            cnt_num_o <= '0;
        end else begin
            gnt_o     <= '0;
            ack_o     <= '0;
            busy_o    <= 1'b0;
            cnt_clr_o <= 1'b0;
            cnt_en_o  <= 1'b0;
            cnt_num_o <= '0;
            case (state_r)
                IDLE: begin
                    if (|req_i) begin
                        state_r   <= CLEAR;
                        owner_r   <= pick_s;
                        len_q_r   <= pick_len_s;
                        gnt_o     <= onehot(pick_s);
                        busy_o    <= 1'b1;
                        cnt_clr_o <= 1'b1;
                        cnt_num_o <= pick_len_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CLEAR: begin
                    if (!owner_req_s) begin
                        state_r <= IDLE;
                        last_r  <= owner_r;
                    end else begin
                        state_r   <= RUN;
                        gnt_o     <= onehot(owner_r);
                        busy_o    <= 1'b1;
                        cnt_en_o  <= 1'b1;
                        cnt_num_o <= len_q_r;
                    end
                end
                RUN: begin
                    // Done takes precedence over a withdrawal in the same cycle.
                    if (cnt_done_i) begin
                        state_r   <= ACK;
                        ack_o     <= onehot(owner_r);
                        busy_o    <= 1'b1;
                        cnt_num_o <= len_q_r;
                    end else if (!owner_req_s) begin
                        state_r <= IDLE;
                        last_r  <= owner_r;
                    end else begin
                        state_r   <= RUN;
                        gnt_o     <= onehot(owner_r);
                        busy_o    <= 1'b1;
                        cnt_en_o  <= 1'b1;
                        cnt_num_o <= len_q_r;
                    end
                end
                ACK: begin
                    state_r <= IDLE;
                    last_r  <= owner_r;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_counter_arbiter.sv
// Bench for ring_counter_arbiter: a timeline model predicts every cycle's outputs,
// and a scoreboard queue of expected acks is drained by a separate monitor.
module tb_ring_counter_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_i;
    logic [N*W-1:0]   len_i;
    logic [N-1:0]     gnt_o;
    logic [N-1:0]     ack_o;
    logic             busy_o;
    logic             cnt_clr_o;
    logic             cnt_en_o;
    logic [W-1:0]     cnt_num_o;
    logic             cnt_done_i;

    ring_counter_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .len_i(len_i),
        .gnt_o(gnt_o), .ack_o(ack_o), .busy_o(busy_o),
        .cnt_clr_o(cnt_clr_o), .cnt_en_o(cnt_en_o), .cnt_num_o(cnt_num_o),
        .cnt_done_i(cnt_done_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ring counter plus an injected stray done pulse.
    logic [W-1:0] cnt = '0;
    logic         spur = 1'b0;
    always @(posedge clk) begin
        if (cnt_clr_o) cnt <= '0;
        else if (cnt_en_o) cnt <= (cnt == cnt_num_o) ? '0 : cnt + 1'b1;
    end
    assign cnt_done_i = (cnt_en_o && (cnt == cnt_num_o)) || spur;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one granted run is a timeline starting at m_start:
    // offset 0 clear, 1..len+1 counting, len+2 ack.
    typedef struct { int owner; int cyc; } exp_t;
    exp_t q[$];
    bit   m_busy = 1'b0;
    int   m_owner, m_start, m_len;
    int   m_last = N - 1;
    int   last_ph;

    function automatic int phase_at(input int c);
        int off;
        if (!m_busy) return 0;
        off = c - m_start;
        if (off == 0) return 1;
        if (off <= m_len + 1) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = N - 1;
        q.delete();
    endtask

    task automatic step(input logic [N-1:0] fr, input logic [N*W-1:0] fl, input bit use_f);
        int c, ph, off, oh, idx;
        bit drop, found;
        logic [N-1:0]   nr;
        logic [N*W-1:0] nl;
        @(negedge clk);
        c   = cyc;
        ph  = phase_at(c);
        off = c - m_start;
        oh  = (ph == 1 || ph == 2) ? (1 << m_owner) : 0;
        last_ph = ph;
        check("gnt", gnt_o, oh);
        check("busy", busy_o, ph != 0);
        check("clr", cnt_clr_o, ph == 1);
        check("en", cnt_en_o, ph == 2);
        if (ph != 3) check("num", cnt_num_o, (ph == 0) ? 0 : m_len);
        if (use_f) begin
            nr = fr;
            nl = fl;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (req_i[k]) begin
                    if (ph != 0 && k == m_owner) begin
                        if (ph == 3) drop = ($urandom_range(0, 1) == 0);
                        else if (ph == 2 && off == m_len + 1) drop = ($urandom_range(0, 3) == 0);
                        else drop = ($urandom_range(0, 39) == 0);
                    end else begin
                        drop = ($urandom_range(0, 59) == 0);
                    end
                    nr[k] = !drop;
                end else begin
                    nr[k] = ($urandom_range(0, 3) == 0);
                end
                nl[k*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 20))
                                                             : W'($urandom_range(0, 6));
            end
        end
        req_i = nr;
        len_i = nl;
        spur  = (ph != 2) && ($urandom_range(0, 7) == 0);
        // Advance the model to cycle c+1.
        case (ph)
            0: if (nr != 0) begin
                found = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    idx = (m_last + i) % N;
                    if (!found && nr[idx]) begin
                        found   = 1'b1;
                        m_owner = idx;
                    end
                end
                m_busy  = 1'b1;
                m_start = c + 1;
                m_len   = int'(nl[m_owner*W +: W]);
                q.push_back('{owner: m_owner, cyc: c + 1 + m_len + 2});
            end
            1: if (!nr[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
                if (q.size() > 0) void'(q.pop_back());
            end
            2: if (off != m_len + 1 && !nr[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
                if (q.size() > 0) void'(q.pop_back());
            end
            default: begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        endcase
    endtask

    // Monitor: every ack pulse must match the head of the scoreboard at its cycle.
    always @(negedge clk) begin
        if (rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("ack", ack_o, 1 << q[0].owner);
                void'(q.pop_front());
            end else if (ack_o != '0) begin
                check("ack_unexpected", ack_o, 0);
            end
        end
    end

    initial begin
        logic [N*W-1:0] lens;
        int found;
        rst   = 1'b0;
        req_i = '0;
        len_i = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt_o, 0);
        check("rst_ack", ack_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_clr", cnt_clr_o, 0);
        check("rst_en", cnt_en_o, 0);
        check("rst_num", cnt_num_o, 0);
        model_reset();
        rst = 1'b1;

        // Single request, len 5.
        lens = {8'd9, 8'd9, 8'd9, 8'd5};
        repeat (10) step(4'b0001, lens, 1'b1);
        repeat (4) step(4'b0000, lens, 1'b1);

        // All requesting, len 2: strict rotation.
        lens = {4{8'd2}};
        repeat (40) step(4'b1111, lens, 1'b1);
        repeat (6) step(4'b0000, lens, 1'b1);

        // Zero length on requester 1.
        lens = {8'd4, 8'd4, 8'd0, 8'd4};
        repeat (4) step(4'b0010, lens, 1'b1);
        repeat (3) step(4'b0000, lens, 1'b1);

        // Long run on requester 3 aborted, requester 0 waiting.
        lens = {8'd200, 8'd1, 8'd1, 8'd3};
        repeat (14) step(4'b1000, lens, 1'b1);
        repeat (3) step(4'b1001, lens, 1'b1);
        repeat (8) step(4'b0001, lens, 1'b1);
        repeat (10) step(4'b0000, lens, 1'b1);

        // Randomized traffic.
        repeat (3000) step('0, '0, 1'b0);

        // Reset while a run is active.
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            step('0, '0, 1'b0);
            if (last_ph == 2) found = 1;
        end
        check("reach_run", found, 1);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_gnt", gnt_o, 0);
        check("rst_mid_en", cnt_en_o, 0);
        check("rst_mid_busy", busy_o, 0);
        @(negedge clk);
        model_reset();
        req_i = '0;
        spur  = 1'b0;
        #1 rst = 1'b1;
        lens = {4{8'd3}};
        repeat (2) step(4'b0110, lens, 1'b1);
        check("gnt_after_rst", gnt_o, 4'b0010);
        repeat (12) step(4'b0110, lens, 1'b1);
        repeat (30) step(4'b0000, lens, 1'b1);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
